instr_cache: RTL
================

// Module: instr_cache
// PURPOSE
//  Direct-mapped instruction cache answering the CPU's PC-driven fetch port.
//  Sits between the CPU fetch path and the 1024-byte instruction memory.
//  Hits return a 32-bit instruction with no stall. Misses raise busywait and
//  refill a 16-byte block from memory over a read/busywait handshake.
// PARAMETERS
//  ADDR_W   10  CPU byte-address width used (PC[9:0]); word-aligned fetches
//  INDEX_W  3   set index bits, giving 8 blocks
//  OFF_W    4   byte offset within a block, giving 16 B = 4 words
//  TAG_W    3   ADDR_W-INDEX_W-OFF_W
// PORTS
//  CLK          in   1    clock; all state updates on posedge
//  RESET        in   1    asynchronous, active-low reset
//  read         in   1    CPU fetch request; held high while busywait=1
//  address      in   10   CPU PC[9:0]: tag[9:7] index[6:4] word[3:2]; [1:0]=0
//  instruction  out  32   fetched word; valid when read=1 and busywait=0
//  busywait     out  1    stall to CPU; PC must not advance while high
//  mem_read     out  1    block read request to instruction memory
//  mem_address  out  6    block address {tag,index}
//  mem_readdata in   128  refill block; byte 0 in [7:0], little-endian words
//  mem_busywait in   1    memory busy; readdata valid on its falling edge cycle
// BEHAVIOUR
//  - Reset (RESET=0, async): all 8 valid bits clear, FSM->IDLE, busywait=0,
//    mem_read=0, mem_address=0, instruction=0. Tag/data arrays are not cleared.
//  - hit = read & valid[index] & (tag_arr[index]==tag). Combinational path.
//  - FSM IDLE: read=0 -> busywait=0, instruction holds its last value.
//    Hit -> busywait=0, instruction=data[index] word[3:2], same cycle.
//    Miss -> busywait=1 combinationally. Next edge: latch {tag,index}, ->MEM_READ.
//  - MEM_READ: mem_read=1, mem_address=latched {tag,index}, busywait=1.
//    Stay while mem_busywait=1. First edge with mem_busywait=0: write
//    mem_readdata into data[idx], tag_arr[idx]=tag, valid[idx]=1, ->UPDATE.
//  - UPDATE: mem_read=0, busywait=1 for one cycle. Next edge ->IDLE, where the
//    re-evaluated access hits.
//  - Miss latency: 1 (detect) + memory cycles + 1 (UPDATE). A hit adds 0 cycles.
//  - Address changes during MEM_READ/UPDATE are ignored; the latched address
//    is used. A refill always completes unless reset intervenes.
//  - Reset mid-refill aborts it. The block stays invalid and mem_read drops
//    immediately.
//  - read dropping during MEM_READ does not abort the refill.
//  - Misaligned address[1:0]!=0: the low bits are ignored.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0].
//    Each increments once per IDLE-state access resolved as hit or miss, and
//    saturates at 16'hFFFF. Reset clears both. The UPDATE-then-hit re-access
//    counts as a hit.
//  ICACHE_STATS_EN undefined: no counters and no extra ports. Behaviour is
//    otherwise identical.
// STRUCTURE
//  Package icache_pkg: state enum {IDLE, MEM_READ, UPDATE}, INDEX_W/OFF_W/TAG_W
//    localparams, helper functions for tag/index/word extraction.
//  Sub-module icache_data_array: 8x128 data storage, 8xTAG_W tags and valid
//    bits, one write port, combinational read port. The FSM and hit logic stay
//    in instr_cache.
// TESTING
//  1. Reset low at t=0, read=1, address=0x000 -> busywait=1, mem_read=1,
//     mem_address=0x00. Memory returns the block after 5 busy cycles. Then
//     UPDATE, then hit with instruction=mem word0.
//  2. After test 1, address=0x004, 0x008, 0x00C -> busywait=0 each cycle,
//     instruction = block words 1..3, mem_read stays 0.
//  3. address=0x080 (tag=1, index=0) after test 1 -> miss, mem_address=0x08,
//     block replaced. Then address=0x000 -> misses again.
//  4. Assert RESET=0 during MEM_READ -> mem_read=0 and busywait=0 asynchronously.
//     After release, address=0x000 misses.
//  5. Change address to 0x3F0 during MEM_READ for 0x010 -> mem_address stays
//     0x01, only index 1 is filled.
//  6. ICACHE_STATS_EN: run tests 1 and 2 -> miss_count=1, hit_count=4.

Source files
------------

// File: rtl/icache_pkg.sv
// Package: icache_pkg
// Shared types, geometry and address helpers for the direct-mapped instruction
// cache. Address layout (10-bit PC): tag[9:7] index[6:4] word[3:2] byte[1:0].
package icache_pkg;

    localparam int ADDR_W   = 10;
    localparam int INDEX_W  = 3;
    localparam int OFF_W    = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFF_W;
    localparam int BLK_W    = TAG_W + INDEX_W;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 128;
    localparam int N_BLOCKS = 1 << INDEX_W;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [BLK_W-1:0]   blk_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [LINE_W-1:0]  line_t;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    function automatic tag_t get_tag(input addr_t a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic index_t get_index(input addr_t a);
        return a[OFF_W +: INDEX_W];
    endfunction

    // Word select within a 16-byte block; byte bits [1:0] are ignored.
    function automatic logic [1:0] get_word(input addr_t a);
        return a[3:2];
    endfunction

endpackage

// File: rtl/icache_if.sv
// Interface: icache_if
// CPU fetch port of the instruction cache.
//   read        CPU -> cache   fetch request, held while busywait is high
//   address     CPU -> cache   PC[9:0]
//   instruction cache -> CPU   fetched word, valid when read=1, busywait=0
//   busywait    cache -> CPU   stall
// Modports: master (CPU side), slave (cache side).
interface icache_if;
    import icache_pkg::*;

    logic  read;
    addr_t address;
    word_t instruction;
    logic  busywait;

    modport master (output read, address, input  instruction, busywait);
    modport slave  (input  read, address, output instruction, busywait);
endinterface

// File: rtl/icache_data_array.sv
// Module: icache_data_array
// Storage for the cache: 8 x 128-bit blocks, 8 tags, 8 valid bits.
// One synchronous write port (refill) and one combinational read port.
//   CLK, RESET         clock, async active-low reset (clears valid bits only)
//   we, w_index,
//   w_tag, w_data      refill write: marks the block valid
//   r_index            read index
//   r_valid, r_tag,
//   r_data             combinational read data
module icache_data_array
    import icache_pkg::*;
(
    input  logic   CLK,
    input  logic   RESET,
    input  logic   we,
    input  index_t w_index,
    input  tag_t   w_tag,
    input  line_t  w_data,
    input  index_t r_index,
    output logic   r_valid,
    output tag_t   r_tag,
    output line_t  r_data
);

    logic [N_BLOCKS-1:0] valid_q;
    tag_t                tag_q  [N_BLOCKS];
    line_t               data_q [N_BLOCKS];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[w_index] <= 1'b1;
        end
    end

    // NOTE: tag and data storage carry no reset; the valid bits alone make
    // stale contents unobservable, and this keeps the arrays RAM-mappable.
    always_ff @(posedge CLK) begin
        if (we) begin
            tag_q[w_index]  <= w_tag;
            data_q[w_index] <= w_data;
        end
    end

    assign r_valid = valid_q[r_index];
    assign r_tag   = tag_q[r_index];
    assign r_data  = data_q[r_index];

endmodule

// File: rtl/instr_cache.sv
// Module: instr_cache
// Direct-mapped instruction cache between the CPU fetch path and a 1 KiB
// instruction memory. Hits return in the same cycle; misses stall the CPU and
// refill a 16-byte block over the mem_read / mem_busywait handshake.
//   CLK, RESET     clock, async active-low reset
//   cpu            icache_if.slave CPU fetch port
//   mem_read       block read request
//   mem_address    block address {tag,index}
//   mem_readdata   refill block, byte 0 in [7:0]
//   mem_busywait   memory busy; data taken on the first cycle it is low
// Optional: define ICACHE_STATS_EN to add saturating hit_count / miss_count.
module instr_cache
    import icache_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    icache_if.slave     cpu,
    output logic        mem_read,
    output blk_t        mem_address,
    input  line_t       mem_readdata,
    input  logic        mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    state_t state_q, state_d;
    blk_t   blk_q;
    word_t  last_instr_q;
    logic   arr_valid;
    tag_t   arr_tag;
    line_t  arr_line;
    logic   hit, idle_hit, idle_miss, busy, fill_we;

    // Byte-offset bits of the PC play no part in a word fetch.
    wire unused_lsbs = ^cpu.address[1:0];

    icache_data_array u_array (
        .CLK     (CLK),
        .RESET   (RESET),
        .we      (fill_we),
        .w_index (blk_q[INDEX_W-1:0]),
        .w_tag   (blk_q[BLK_W-1 -: TAG_W]),
        .w_data  (mem_readdata),
        .r_index (get_index(cpu.address)),
        .r_valid (arr_valid),
        .r_tag   (arr_tag),
        .r_data  (arr_line)
    );

    assign hit       = cpu.read & arr_valid & (arr_tag == get_tag(cpu.address));
    assign idle_hit  = (state_q == IDLE) & hit;
    assign idle_miss = (state_q == IDLE) & cpu.read & ~hit;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        state_d  = state_q;
        busy     = 1'b0;
        mem_read = 1'b0;
        fill_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (idle_miss) begin
                    busy    = 1'b1;
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    fill_we = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            blk_q        <= '0;
            last_instr_q <= '0;
        end else begin
            state_q <= state_d;
            // The block address is captured once; later PC changes are ignored.
            if (idle_miss) blk_q <= cpu.address[ADDR_W-1:OFF_W];
            if (idle_hit)  last_instr_q <= cpu.instruction;
        end
    end

    // Reset must release the CPU even though an empty cache would miss.
    assign cpu.busywait    = RESET & busy;
    assign cpu.instruction = idle_hit ? arr_line[get_word(cpu.address)*WORD_W +: WORD_W]
                                      : last_instr_q;
    assign mem_address     = blk_q;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (idle_hit  && hit_count  != 16'hFFFF) hit_count  <= hit_count  + 16'd1;
            if (idle_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
